// File: rtl/alu_rs_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types : shared types for the ALU reservation station scheduler.
//   alu_op_e       - add/logic functional-unit operation codes
//   decode_info_t  - decoded instruction payload carried through the station
//   rs_tag_t       - physical register tag container (widest supported tag)
//   rs_entry_t     - one station entry: valid, info, pd, ps1, ps2, rdy1, rdy2
//   tag_match()    - result-broadcast tag comparison helper
// Tags narrower than RS_TAG_MAX_BITS are stored zero-extended, so comparing
// full-width containers is equivalent to comparing the real tags.
// -----------------------------------------------------------------------------
package rv32i_types;

  localparam int unsigned RS_TAG_MAX_BITS = 8;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic        use_imm;
    logic [11:0] imm;
  } decode_info_t;

  typedef logic [RS_TAG_MAX_BITS-1:0] rs_tag_t;

  typedef struct packed {
    logic         valid;
    decode_info_t info;
    rs_tag_t      pd;
    rs_tag_t      ps1;
    rs_tag_t      ps2;
    logic         rdy1;
    logic         rdy2;
  } rs_entry_t;

  function automatic logic tag_match(input logic cv, input rs_tag_t a, input rs_tag_t b);
    return cv && (a == b);
  endfunction

endpackage

// File: rtl/alu_rs_scheduler_age_select.sv
// -----------------------------------------------------------------------------
// age_select : oldest-eligible picker driven by an age matrix.
//   i_eligible [N]   - entries that could issue this cycle
//   i_age [N][N]     - i_age[a][b] set means entry a is older than entry b
//   o_grant [N]      - one-hot grant of the eligible entry with no older
//                      eligible entry
//   o_valid          - at least one entry is eligible
// -----------------------------------------------------------------------------
module age_select #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        i_eligible,
  input  logic [N-1:0][N-1:0] i_age,
  output logic [N-1:0]        o_grant,
  output logic                o_valid
);

  always_comb begin
    o_grant = '0;
    for (int unsigned i = 0; i < N; i++) begin
      logic w_blocked;
      w_blocked = 1'b0;
      for (int unsigned j = 0; j < N; j++) begin
        if (j != i && i_eligible[j] && i_age[j][i]) w_blocked = 1'b1;
      end
      o_grant[i] = i_eligible[i] && !w_blocked;
    end
  end

  assign o_valid = |i_eligible;

endmodule

// File: rtl/alu_rs_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rs_scheduler : reservation station for the add/logic functional unit.
//   clk, rst (sync, active-high), flush (drop all entries)
//   dispatch_valid/ready, dispatch_info, dispatch_pd/ps1/ps2, dispatch_psN_rdy
//   cdb_valid, cdb_pd           - result broadcast used for wakeup
//   issue_valid/ready, issue_info, issue_pd/ps1/ps2 - oldest ready entry
//   occupancy                   - registered count of valid entries
// Optional macro ALU_RS_WAKEUP_BYPASS_EN: a source matching the current
// broadcast counts as ready for selection in the same cycle.
// -----------------------------------------------------------------------------
module alu_rs_scheduler
  import rv32i_types::*;
#(
  parameter int unsigned PHYS_REG_BITS = 6,
  parameter int unsigned NUM_ENTRIES   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             dispatch_valid,
  output logic                             dispatch_ready,
  input  decode_info_t                     dispatch_info,
  input  logic [PHYS_REG_BITS-1:0]         dispatch_pd,
  input  logic [PHYS_REG_BITS-1:0]         dispatch_ps1,
  input  logic [PHYS_REG_BITS-1:0]         dispatch_ps2,
  input  logic                             dispatch_ps1_rdy,
  input  logic                             dispatch_ps2_rdy,
  input  logic                             cdb_valid,
  input  logic [PHYS_REG_BITS-1:0]         cdb_pd,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output decode_info_t                     issue_info,
  output logic [PHYS_REG_BITS-1:0]         issue_pd,
  output logic [PHYS_REG_BITS-1:0]         issue_ps1,
  output logic [PHYS_REG_BITS-1:0]         issue_ps2,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(NUM_ENTRIES + 1);
  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  rs_entry_t                               r_ent [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] r_age;
  logic [OCC_W-1:0]                        r_occ;

  rs_tag_t                  w_cdb_tag;
  logic [NUM_ENTRIES-1:0]   w_valid;
  logic [NUM_ENTRIES-1:0]   w_hit1;
  logic [NUM_ENTRIES-1:0]   w_hit2;
  logic [NUM_ENTRIES-1:0]   w_src1_ok;
  logic [NUM_ENTRIES-1:0]   w_src2_ok;
  logic [NUM_ENTRIES-1:0]   w_eligible;
  logic [NUM_ENTRIES-1:0]   w_grant;
  logic                     w_any;
  logic [IDX_W-1:0]         w_free_idx;
  rs_entry_t                w_new;
  rs_entry_t                w_sel;
  logic                     w_dispatch;
  logic                     w_issue;

  assign w_cdb_tag = rs_tag_t'(cdb_pd);

  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      w_valid[i]   = r_ent[i].valid;
      w_hit1[i]    = tag_match(cdb_valid, r_ent[i].ps1, w_cdb_tag);
      w_hit2[i]    = tag_match(cdb_valid, r_ent[i].ps2, w_cdb_tag);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
      w_src1_ok[i] = r_ent[i].rdy1 | w_hit1[i];
      w_src2_ok[i] = r_ent[i].rdy2 | w_hit2[i];
`else
      w_src1_ok[i] = r_ent[i].rdy1;
      w_src2_ok[i] = r_ent[i].rdy2;
`endif
      w_eligible[i] = w_valid[i] & w_src1_ok[i] & w_src2_ok[i];
    end
  end

  age_select #(
    .N (NUM_ENTRIES)
  ) u_age_select (
    .i_eligible (w_eligible),
    .i_age      (r_age),
    .o_grant    (w_grant),
    .o_valid    (w_any)
  );

  // Lowest-index free slot; scanned high-to-low so the lowest index wins.
  always_comb begin
    w_free_idx = '0;
    for (int unsigned i = NUM_ENTRIES; i > 0; i--) begin
      if (!w_valid[i-1]) w_free_idx = IDX_W'(i - 1);
    end
  end

  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.info  = dispatch_info;
    w_new.pd    = rs_tag_t'(dispatch_pd);
    w_new.ps1   = rs_tag_t'(dispatch_ps1);
    w_new.ps2   = rs_tag_t'(dispatch_ps2);
    w_new.rdy1  = dispatch_ps1_rdy | tag_match(cdb_valid, rs_tag_t'(dispatch_ps1), w_cdb_tag);
    w_new.rdy2  = dispatch_ps2_rdy | tag_match(cdb_valid, rs_tag_t'(dispatch_ps2), w_cdb_tag);
  end

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (w_grant[i]) w_sel = r_ent[i];
    end
  end

  // rst is folded in so both handshake outputs show reset values while it is held.
  assign dispatch_ready = rst || (r_occ != OCC_W'(NUM_ENTRIES));
  assign issue_valid    = w_any && !flush && !rst;
  assign issue_info     = w_sel.info;
  assign issue_pd       = w_sel.pd[PHYS_REG_BITS-1:0];
  assign issue_ps1      = w_sel.ps1[PHYS_REG_BITS-1:0];
  assign issue_ps2      = w_sel.ps2[PHYS_REG_BITS-1:0];
  assign occupancy      = r_occ;

  assign w_dispatch = dispatch_valid && dispatch_ready && !flush && !rst;
  assign w_issue    = issue_valid && issue_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) r_ent[i] <= '0;
      r_age <= '0;
      r_occ <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) r_ent[i].valid <= 1'b0;
      r_occ <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (w_valid[i] && w_hit1[i]) r_ent[i].rdy1 <= 1'b1;
        if (w_valid[i] && w_hit2[i]) r_ent[i].rdy2 <= 1'b1;
        if (w_issue && w_grant[i])   r_ent[i].valid <= 1'b0;
      end
      if (w_dispatch) begin
        r_ent[w_free_idx] <= w_new;
        // New entry is younger than every entry valid right now.
        for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
          r_age[w_free_idx][j] <= 1'b0;
          r_age[j][w_free_idx] <= (IDX_W'(j) != w_free_idx) && w_valid[j];
        end
      end
      unique case ({w_dispatch, w_issue})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_rs_scheduler : directed scenarios followed by random traffic, every
// cycle compared against a slot/sequence-number reference model.
// -----------------------------------------------------------------------------
module tb_alu_rs_scheduler;
  import rv32i_types::*;

  localparam int N  = 4;
  localparam int PB = 6;
  localparam int INFO_W = $bits(decode_info_t);

  logic          clk;
  logic          rst, flush;
  logic          dispatch_valid, dispatch_ready;
  decode_info_t  dispatch_info;
  logic [PB-1:0] dispatch_pd, dispatch_ps1, dispatch_ps2;
  logic          dispatch_ps1_rdy, dispatch_ps2_rdy;
  logic          cdb_valid;
  logic [PB-1:0] cdb_pd;
  logic          issue_valid, issue_ready;
  decode_info_t  issue_info;
  logic [PB-1:0] issue_pd, issue_ps1, issue_ps2;
  logic [2:0]    occupancy;

  alu_rs_scheduler #(
    .PHYS_REG_BITS (PB),
    .NUM_ENTRIES   (N)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .dispatch_valid   (dispatch_valid),
    .dispatch_ready   (dispatch_ready),
    .dispatch_info    (dispatch_info),
    .dispatch_pd      (dispatch_pd),
    .dispatch_ps1     (dispatch_ps1),
    .dispatch_ps2     (dispatch_ps2),
    .dispatch_ps1_rdy (dispatch_ps1_rdy),
    .dispatch_ps2_rdy (dispatch_ps2_rdy),
    .cdb_valid        (cdb_valid),
    .cdb_pd           (cdb_pd),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_info       (issue_info),
    .issue_pd         (issue_pd),
    .issue_ps1        (issue_ps1),
    .issue_ps2        (issue_ps2),
    .occupancy        (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-slot contents plus a dispatch sequence number;
  // the oldest ready entry is simply the one with the smallest number.
  typedef struct {
    bit            v;
    decode_info_t  info;
    logic [PB-1:0] pd, ps1, ps2;
    bit            r1, r2;
    int unsigned   seq;
  } ment_t;

  ment_t       m [N];
  int unsigned seq_ctr;
  int          tests;
  int          fails;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit dv, input decode_info_t di, input logic [PB-1:0] pd,
                      input logic [PB-1:0] ps1, input logic [PB-1:0] ps2,
                      input bit r1, input bit r2, input bit cv, input logic [PB-1:0] cpd,
                      input bit ir, input bit fl, input bit rs);
    int cnt, sel;
    bit exp_dr, exp_iv, e1, e2;
    dispatch_valid = dv; dispatch_info = di; dispatch_pd = pd;
    dispatch_ps1 = ps1; dispatch_ps2 = ps2;
    dispatch_ps1_rdy = r1; dispatch_ps2_rdy = r2;
    cdb_valid = cv; cdb_pd = cpd; issue_ready = ir; flush = fl; rst = rs;
    #6;
    cnt = 0; sel = -1;
    for (int i = 0; i < N; i++) begin
      if (m[i].v) cnt++;
      e1 = m[i].r1 || (BYP && cv && cpd == m[i].ps1);
      e2 = m[i].r2 || (BYP && cv && cpd == m[i].ps2);
      if (m[i].v && e1 && e2 && (sel < 0 || m[i].seq < m[sel].seq)) sel = i;
    end
    exp_dr = rs || (cnt != N);
    exp_iv = (sel >= 0) && !fl && !rs;
    chk("dispatch_ready", 32'(dispatch_ready), 32'(exp_dr));
    chk("issue_valid", 32'(issue_valid), 32'(exp_iv));
    if (!rs) chk("occupancy", 32'(occupancy), 32'(cnt));
    if (exp_iv) begin
      chk("issue_pd", 32'(issue_pd), 32'(m[sel].pd));
      chk("issue_ps1", 32'(issue_ps1), 32'(m[sel].ps1));
      chk("issue_ps2", 32'(issue_ps2), 32'(m[sel].ps2));
      chk("issue_info", 32'(issue_info), 32'(m[sel].info));
    end
    // advance the model to the state after this clock edge
    if (rs || fl) begin
      for (int i = 0; i < N; i++) m[i].v = 1'b0;
    end else begin
      int fr;
      fr = -1;
      for (int i = N - 1; i >= 0; i--) if (!m[i].v) fr = i;
      for (int i = 0; i < N; i++) begin
        if (m[i].v && cv && cpd == m[i].ps1) m[i].r1 = 1'b1;
        if (m[i].v && cv && cpd == m[i].ps2) m[i].r2 = 1'b1;
      end
      if (exp_iv && ir) m[sel].v = 1'b0;
      if (dv && cnt != N) begin
        m[fr].v = 1'b1; m[fr].info = di; m[fr].pd = pd;
        m[fr].ps1 = ps1; m[fr].ps2 = ps2;
        m[fr].r1 = r1 || (cv && cpd == ps1);
        m[fr].r2 = r2 || (cv && cpd == ps2);
        m[fr].seq = seq_ctr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic decode_info_t rinfo();
    return decode_info_t'(INFO_W'($urandom));
  endfunction

  initial begin
    tests = 0; fails = 0; seq_ctr = 0;
    for (int i = 0; i < N; i++) m[i] = '{default: '0};
    #1;
    // reset
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // single ready entry: issue next cycle, then empty
    step(1, rinfo(), 1, 2, 3, 1, 1, 0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // A waits on tag 5, B ready: B first, A after broadcast
    step(1, rinfo(), 10, 5, 6, 0, 1, 0, 0, 0, 0, 0);
    step(1, rinfo(), 11, 7, 8, 1, 1, 0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // fill, then dispatch held while one issues
    for (int k = 0; k < N; k++) step(1, rinfo(), 6'(20 + k), 1, 2, 1, 1, 0, 0, 0, 0, 0);
    step(1, rinfo(), 30, 1, 2, 1, 1, 0, 0, 1, 0, 0);
    step(1, rinfo(), 31, 1, 2, 1, 1, 0, 0, 0, 0, 0);
    step(1, rinfo(), 32, 1, 2, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < N + 1; k++) step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // wake in scrambled order; issue still follows allocation age
    for (int k = 0; k < N; k++) step(1, rinfo(), 6'(40 + k), 6'(50 + k), 3, 0, 1, 0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 1, 52, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 1, 50, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 1, 53, 1, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 1, 51, 1, 0, 0);
    for (int k = 0; k < N; k++) step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // same-cycle capture of broadcast at dispatch
    step(1, rinfo(), 12, 4, 9, 1, 0, 1, 9, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // flush with concurrent dispatch, then reset mid-operation
    for (int k = 0; k < 3; k++) step(1, rinfo(), 6'(k), 6'(60 + k), 2, 0, 1, 0, 0, 0, 0, 0);
    step(1, rinfo(), 13, 1, 1, 1, 1, 0, 0, 1, 1, 0);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, rinfo(), 14, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(1, rinfo(), 15, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(1, rinfo(), 16, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // random traffic
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom), rinfo(), 6'($urandom), 6'($urandom_range(0, 15)),
           6'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), 1'($urandom), 6'($urandom_range(0, 15)),
           1'($urandom), ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
